nn_fc_engine: RTL
=================

Name: nn_fc_engine

Overview:
- Responder side of the processor's run_inference/ready handshake: the neural accelerator that sits on the 8-bit port of the shared mixed-width dual-port RAM.
- On a run_inference request it computes one fully-connected int8 layer, out[j] = requant(bias[j] + sum_i x[i]*w[j][i]), from operands stored in the RAM.
- Results are written back to the same RAM, then ready is raised; the processor's pulse generator turns that rising edge into an interrupt.

Parameters:
- N_IN, 16, inputs per neuron (>=1)
- N_OUT, 8, neurons (>=1)
- IN_BASE, 10'h000, byte address of x[0]
- W_BASE, 10'h040, byte address of w[0][0]; row-major, w[j][i] at W_BASE+j*N_IN+i
- B_BASE, 10'h0C0, byte address of bias[0]
- OUT_BASE, 10'h0E0, byte address of out[0]
- ACC_W, 24, signed accumulator width
- SHIFT, 7, requantisation right-shift

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- run_inference  in  1  start request, one-cycle pulse from the decoder
- ready  out  1  layer complete; held until the next accepted request
- nn_address  out  10  RAM byte address
- nn_wd  out  8  RAM write data
- nn_we  out  1  RAM write enable
- nn_rd  in  8  RAM read data, valid exactly 1 cycle after the address is presented

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: ready=0, nn_we=0, nn_address=0, nn_wd=0, state=IDLE, all counters and the accumulator 0.
- ready must reset to 0; a 1 at reset would produce a spurious interrupt pulse.
- Bytes are signed two's-complement int8. The processor writes them as 32-bit words, little-endian: byte addr = word*4 + lane.
- States and transitions:
  - IDLE: if run_inference=1, go to BIAS_RD; set j=0, wptr=W_BASE, ready<=0.
  - BIAS_RD: nn_address=B_BASE+j; go to BIAS_CAP.
  - BIAS_CAP: acc <= sext(nn_rd) <<< SHIFT; i=0; go to X_RD.
  - X_RD: nn_address=IN_BASE+i; go to W_RD.
  - W_RD: xreg <= nn_rd; nn_address=wptr; go to MAC.
  - MAC: acc <= acc + xreg*sext(nn_rd) (signed 16-bit product, sign-extended); wptr++.
    - If i==N_IN-1, go to WR; otherwise i++ and go to X_RD.
  - WR: nn_we=1; nn_address=OUT_BASE+j; nn_wd=requant(acc).
    - If j==N_OUT-1, go to IDLE with ready<=1; otherwise j++ and go to BIAS_RD.
- nn_we is high only in WR, for exactly one cycle per neuron. No other state writes.
- requant(acc) = saturate(acc >>> SHIFT), where >>> is an arithmetic (floor) shift.
- Latency: ready rises on the edge N_OUT*(3*N_IN+3) edges after the edge that samples run_inference.
- Address arithmetic is mod 1024 (wrap-around). Accumulator overflow wraps mod 2^ACC_W; no sticky flag.
- run_inference in any state other than IDLE is ignored, including WR on the final edge.
- run_inference in IDLE with ready=1 is accepted; ready falls on that edge.
- Reset mid-operation: returns to IDLE immediately with ready=0 and nn_we=0. Outputs already written stay in RAM; no completion is signalled.

Optional Feature:
- NN_RELU_EN defined: ReLU applied; saturation range is [0,127], negatives write 8'h00.
- NN_RELU_EN undefined: saturation range is [-128,127]; negatives are written as two's complement.

Decomposition:
- Package nn_pkg holds:
  - state enum nn_state_t {IDLE, BIAS_RD, BIAS_CAP, X_RD, W_RD, MAC, WR}
  - NN_ADDR_W=10, NN_DATA_W=8
  - localparam cycles-per-neuron = 3*N_IN+3
- Sub-module nn_requant: combinational shift, optional ReLU and saturation, parameterised by ACC_W and SHIFT.
- The FSM, counters and MAC stay in nn_fc_engine.

Test Plan:
- N_IN=2, N_OUT=1, SHIFT=0; x={3,-2}, w={4,5}, bias=1 -> byte OUT_BASE=8'h03; ready rises exactly 9 edges after the start edge; exactly one nn_we cycle.
- Same config; x={127,127}, w={127,127}, bias=0 -> 8'h7F (positive saturation).
- Same config; x={10,0}, w={-5,0}, bias=0 -> 8'h00 with NN_RELU_EN, 8'hCE without; with x={-128,-128}, w={127,127} and no RELU -> 8'h80.
- Defaults (SHIFT=7); x[0]=64, w[j][0]=64, bias[j]=1, all other x and w =0 -> every out[j]=8'h21 (33); ready at edge 8*51=408; 8 writes at OUT_BASE..OUT_BASE+7 in order.
- run_inference pulses during MAC and during the final WR -> ignored; ready timing and results unchanged; a new pulse while ready=1 drops ready next edge and recomputes.
- reset asserted asynchronously mid-MAC -> ready=0, nn_we=0 at once; after release, a fresh run produces correct results and normal latency.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the fully-connected int8 engine.
//   nn_state_t           - engine FSM states
//   NN_ADDR_W/NN_DATA_W  - widths of the 8-bit RAM port
//   NN_CYC_PER_NEURON    - cycles per neuron for the default 16-input layer
//   nn_cycles_per_neuron - same figure for any input count
package nn_pkg;

  localparam int NN_ADDR_W = 10;
  localparam int NN_DATA_W = 8;
  localparam int NN_N_IN_DEFAULT = 16;
  localparam int NN_CYC_PER_NEURON = 3 * NN_N_IN_DEFAULT + 3;

  typedef enum logic [2:0] {
    IDLE,
    BIAS_RD,
    BIAS_CAP,
    X_RD,
    W_RD,
    MAC,
    WR
  } nn_state_t;

  // Bias read + bias capture + write-back, plus three cycles per input
  function automatic int nn_cycles_per_neuron(input int n_in);
    return 3 * n_in + 3;
  endfunction

endpackage

// File: rtl/nn_requant.sv
// nn_requant: combinational requantisation of one accumulator to int8.
// Arithmetic (floor) right shift by SHIFT, then saturation.
// Build option: define NN_RELU_EN to clamp negatives to zero (range [0,127]);
// otherwise the range is [-128,127].
// Ports:
//   acc - signed accumulator, ACC_W bits
//   q   - requantised byte
module nn_requant #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic [ACC_W-1:0] acc,
  output logic [7:0]       q
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
`ifdef NN_RELU_EN
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(0);
`else
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);
`endif

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
    if (shifted > SAT_HI) begin
      q = SAT_HI[7:0];
    end else if (shifted < SAT_LO) begin
      q = SAT_LO[7:0];
    end else begin
      q = shifted[7:0];
    end
  end

endmodule

// File: rtl/nn_fc_engine.sv
// nn_fc_engine: one fully-connected int8 layer computed out of a shared RAM.
//   out[j] = requant(bias[j] + sum_i x[i]*w[j][i]), written to OUT_BASE+j.
// Build option: NN_RELU_EN (see nn_requant) selects ReLU saturation.
// Ports:
//   clk, reset     - clock; asynchronous active-high reset
//   run_inference  - start pulse, accepted only in IDLE
//   ready          - layer complete; held until the next accepted start
//   nn_address     - RAM byte address (registered)
//   nn_wd, nn_we   - RAM write data / write enable (one cycle per neuron)
//   nn_rd          - RAM read data, valid one cycle after the address
// Handshake: run_inference is a request sampled only in IDLE; ready is the
// completion level, raised on the edge that finishes the last write and
// cleared on the edge that accepts the next request.
module nn_fc_engine
  import nn_pkg::*;
#(
  parameter int                   N_IN     = 16,
  parameter int                   N_OUT    = 8,
  parameter logic [NN_ADDR_W-1:0] IN_BASE  = 10'h000,
  parameter logic [NN_ADDR_W-1:0] W_BASE   = 10'h040,
  parameter logic [NN_ADDR_W-1:0] B_BASE   = 10'h0C0,
  parameter logic [NN_ADDR_W-1:0] OUT_BASE = 10'h0E0,
  parameter int                   ACC_W    = 24,
  parameter int                   SHIFT    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_inference,
  output logic                 ready,
  output logic [NN_ADDR_W-1:0] nn_address,
  output logic [NN_DATA_W-1:0] nn_wd,
  output logic                 nn_we,
  input  logic [NN_DATA_W-1:0] nn_rd
);

  localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

  nn_state_t               state;
  logic [I_W-1:0]          i;
  logic [J_W-1:0]          j;
  logic [NN_ADDR_W-1:0]    wptr;
  logic [NN_DATA_W-1:0]    xreg;
  logic signed [ACC_W-1:0] acc;

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] acc_mac;
  logic signed [ACC_W-1:0] bias_ext;
  logic [NN_DATA_W-1:0]    q;

  // Product of the latched x with the weight arriving this cycle; the sum
  // wraps mod 2^ACC_W.
  assign prod     = 16'($signed(xreg)) * 16'($signed(nn_rd));
  assign acc_mac  = acc + ACC_W'(prod);
  // Bias is pre-scaled so it lands on the same fixed-point grid as the sum.
  assign bias_ext = ACC_W'($signed(nn_rd)) <<< SHIFT;

  // Requantise the post-MAC value so the byte is ready on the transition
  // into WR without an extra cycle.
  nn_requant #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_requant (
    .acc(acc_mac),
    .q  (q)
  );

  // Addresses are loaded on the transition into the state that presents
  // them, so the RAM sees each address for the whole state cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      wptr       <= '0;
      xreg       <= '0;
      acc        <= '0;
      ready      <= 1'b0;
      nn_address <= '0;
      nn_wd      <= '0;
      nn_we      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run_inference) begin
            state      <= BIAS_RD;
            j          <= '0;
            wptr       <= W_BASE;
            ready      <= 1'b0;
            nn_address <= B_BASE;
          end
        end
        BIAS_RD: begin
          state <= BIAS_CAP;
        end
        BIAS_CAP: begin
          acc        <= bias_ext;
          i          <= '0;
          nn_address <= IN_BASE;
          state      <= X_RD;
        end
        X_RD: begin
          nn_address <= wptr;
          state      <= W_RD;
        end
        W_RD: begin
          xreg  <= nn_rd;
          state <= MAC;
        end
        MAC: begin
          acc  <= acc_mac;
          wptr <= wptr + 10'd1;
          if (i == I_LAST) begin
            nn_we      <= 1'b1;
            nn_address <= OUT_BASE + NN_ADDR_W'(j);
            nn_wd      <= q;
            state      <= WR;
          end else begin
            i          <= i + I_W'(1);
            nn_address <= IN_BASE + NN_ADDR_W'(i) + 10'd1;
            state      <= X_RD;
          end
        end
        WR: begin
          nn_we <= 1'b0;
          if (j == J_LAST) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            j          <= j + J_W'(1);
            nn_address <= B_BASE + NN_ADDR_W'(j) + 10'd1;
            state      <= BIAS_RD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
